mac_job_sequencer: RTL
======================

# mac_job_sequencer

Controller that shares one generic multiply-accumulate unit (multiplier plus `AccCycles`-deep accumulator) between `NUM_REQ` requesters. It grants the MAC to one requester at a time, round-robin. For each granted job it:
- clears the accumulator,
- streams exactly `AccCycles` operand pairs through a valid/ready handshake,
- waits for the accumulator to settle,
- returns the result tagged with the requester id.

It sits between the feature-extraction front ends and the MAC datapath.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters (2..8)
- `bitwidthA`, 8: operand A width
- `bitwidthB`, 8: operand B width
- `AccCycles`, 400: operand pairs per job
- `bitwidthAccRes`, 25: accumulator result width
- `DRAIN_CYCLES`, 2: cycles from the last `mac_newData` until `mac_result` is final
- `TIMEOUT`, 1024: idle-operand limit (only with the macro)

Ports:
- `clk`  in  1  clock. One clock domain; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset
- `req`  in  NUM_REQ  job request, one bit per requester
- `opA_in`  in  NUM_REQ*bitwidthA  packed operand A; requester i uses slice i
- `opB_in`  in  NUM_REQ*bitwidthB  packed operand B
- `op_valid`  in  NUM_REQ  operand pair valid
- `op_ready`  out  NUM_REQ  operand pair accepted
- `mac_reset`  out  1  accumulator clear, active-high
- `mac_newData`  out  1  accumulate-enable strobe
- `mac_opA`  out  bitwidthA  registered operand A
- `mac_opB`  out  bitwidthB  registered operand B
- `mac_result`  in  bitwidthAccRes  accumulator output
- `res_valid`  out  1  result available
- `res_ready`  in  1  result consumer ready
- `res_id`  out  clog2(NUM_REQ)  id of the requester that owns the result
- `res_data`  out  bitwidthAccRes  captured result
- `res_err`  out  1  job aborted by timeout (always 0 without the macro)
- `busy`  out  1  state is not IDLE

## Operation
- States: IDLE, CLEAR, ACCUM, DRAIN, OUTPUT.
- **IDLE**
  - If `req` is nonzero, the arbiter picks the first set bit at or after `rr_ptr`, wrapping round.
  - The grant is registered into `gnt_id`; next state is CLEAR.
  - `req` is sampled only in IDLE. Deasserting it mid-job has no effect.
- **CLEAR**
  - `mac_reset` = 1 for exactly 1 cycle; `cnt` <= 0.
  - Next state is ACCUM.
- **ACCUM**
  - `op_ready[gnt_id]` = (`cnt` < `AccCycles`). All other `op_ready` bits are 0.
  - On a transfer (`op_valid[gnt_id] & op_ready[gnt_id]`):
    - `mac_opA`/`mac_opB` <= the selected slices;
    - `mac_newData` <= 1;
    - `cnt` <= `cnt`+1.
  - With no transfer, `mac_newData` <= 0 and `cnt` holds (stall).
  - When `cnt` reaches `AccCycles`, next state is DRAIN.
- **DRAIN**
  - Counts `DRAIN_CYCLES` cycles; `mac_newData` = 0.
  - Then `res_data` <= `mac_result`, `res_id` <= `gnt_id`, and next state is OUTPUT.
- **OUTPUT**
  - `res_valid` = 1; `res_data`/`res_id` stay stable until `res_ready`.
  - On the handshake: `rr_ptr` <= `gnt_id`+1 (mod `NUM_REQ`), next state is IDLE.
- Width rules:
  - `cnt` is clog2(`AccCycles`+1) bits.
  - The product is bitwidthA+bitwidthB bits; overflow is the accumulator's responsibility.
  - `res_data` is a straight copy of `mac_result`.
- Reset values: every output 0; state IDLE; `rr_ptr` 0; `gnt_id` 0; `cnt` 0.
- Reset asserted mid-job: the job is dropped immediately and no result is produced. The next job's CLEAR purges the stale accumulator.

## Timing
- Grant to first `op_ready`: 2 cycles (IDLE→CLEAR→ACCUM).
- Operand acceptance to `mac_newData`/operands: 1 cycle (registered).
- Zero-stall job, from `req` to `res_valid`: 1+1+`AccCycles`+`DRAIN_CYCLES`+1 cycles.
- `res_ready` may already be high when `res_valid` rises; OUTPUT then lasts 1 cycle.
- Back-to-back jobs: IDLE costs 1 cycle between jobs. No job overlap.

## Configuration
- `MAC_JOB_SEQ_TIMEOUT_EN` defined:
  - An idle counter in ACCUM counts consecutive no-transfer cycles and resets on each transfer.
  - Reaching `TIMEOUT` aborts the job and goes straight to OUTPUT with `res_err` = 1 and `res_data` = 0.
- Undefined: the counter is not built, `res_err` is tied to 0, and ACCUM waits indefinitely.

## Structure
- Package `mac_job_seq_pkg` holds:
  - the state enum;
  - the clog2 helper function;
  - localparams for the count and id widths.
- One sub-module, `rr_arbiter`: a combinational round-robin pick from `req` and `rr_ptr`, returning `gnt_id` and `gnt_any`.
- The FSM, counters and output registers live in the top level.

## Test plan
- **Single job:** `AccCycles`=4, requester 0 with A=1,2,3,4 and B=2. Expect `res_data`=20, `res_id`=0, and `res_valid` exactly 1+1+4+2+1 cycles after `req`.
- **Contention:** `req`=2'b11 held for three jobs. Expect grants in the order 0, 1, 0, and `op_ready[1]` never high while requester 0 is granted.
- **Stall:** drop `op_valid` for 3 cycles mid-stream. Expect `cnt` to hold, `mac_newData`=0 for those cycles, and the result unchanged.
- **Backpressure:** hold `res_ready` low for 5 cycles. Expect `res_valid`, `res_data` and `res_id` stable, and no new `op_ready`.
- **Reset mid-ACCUM:** assert reset after 2 pairs. Expect all outputs 0 at once; the next job's result is correct with no carry-over.
- **With `MAC_JOB_SEQ_TIMEOUT_EN`, `TIMEOUT`=8:** stop `op_valid` at once. Expect `res_valid` with `res_err`=1 and `res_data`=0 after 8 idle cycles.

Source files
------------

// File: rtl/mac_job_seq_pkg.sv
// Shared types and helpers for the MAC job sequencer.
// Optional feature macro used by this slice: MAC_JOB_SEQ_TIMEOUT_EN.
package mac_job_seq_pkg;

    // Job sequencing states.
    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StAccum,
        StDrain,
        StOutput
    } seqState_e;

    // Ceiling log2, never below 1 for a value of 2 or more; clog2(1) is 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned pow;
        result = 0;
        pow    = 1;
        while (pow < value) begin
            pow    = pow << 1;
            result = result + 1;
        end
        return result;
    endfunction

    // Default configuration and the widths it implies.
    localparam int unsigned DefNumReq    = 2;
    localparam int unsigned DefAccCycles = 400;
    localparam int unsigned DefIdWidth   = clog2(DefNumReq);
    localparam int unsigned DefCntWidth  = clog2(DefAccCycles + 1);

endpackage

// File: rtl/mac_job_sequencer_if.sv
// Requester, MAC datapath and result-consumer signals of the MAC job sequencer.
// slave is the sequencer's view, master the view of everything around it.
interface mac_job_sequencer_if
    import mac_job_seq_pkg::*;
#(
    parameter int unsigned NUM_REQ        = DefNumReq,
    parameter int unsigned bitwidthA      = 8,
    parameter int unsigned bitwidthB      = 8,
    parameter int unsigned bitwidthAccRes = 25
);
    localparam int unsigned idW = clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*bitwidthA-1:0] opA_in;
    logic [NUM_REQ*bitwidthB-1:0] opB_in;
    logic [NUM_REQ-1:0]           op_valid;
    logic [NUM_REQ-1:0]           op_ready;
    logic                         mac_reset;
    logic                         mac_newData;
    logic [bitwidthA-1:0]         mac_opA;
    logic [bitwidthB-1:0]         mac_opB;
    logic [bitwidthAccRes-1:0]    mac_result;
    logic                         res_valid;
    logic                         res_ready;
    logic [idW-1:0]               res_id;
    logic [bitwidthAccRes-1:0]    res_data;
    logic                         res_err;
    logic                         busy;

    modport slave (
        input  req, opA_in, opB_in, op_valid, mac_result, res_ready,
        output op_ready, mac_reset, mac_newData, mac_opA, mac_opB,
               res_valid, res_id, res_data, res_err, busy
    );

    modport master (
        output req, opA_in, opB_in, op_valid, mac_result, res_ready,
        input  op_ready, mac_reset, mac_newData, mac_opA, mac_opB,
               res_valid, res_id, res_data, res_err, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rrPtr, wrapping round.
module rr_arbiter
    import mac_job_seq_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefNumReq,
    parameter int unsigned idW     = DefIdWidth
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [idW-1:0]     rrPtr,
    output logic [idW-1:0]     gntId,
    output logic               gntAny
);

    // Lowest set bit overall is the wrap-round fallback; lowest set bit at/after rrPtr wins.
    always_comb begin
        gntId  = '0;
        gntAny = 1'b0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                gntId  = idW'(i);
                gntAny = 1'b1;
            end
        end
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req[i] && (idW'(i) >= rrPtr)) begin
                gntId = idW'(i);
            end
        end
    end

endmodule

// File: rtl/mac_job_sequencer.sv
// Shares one multiply-accumulate unit between NUM_REQ requesters, one job at a time.
// Define MAC_JOB_SEQ_TIMEOUT_EN to abort a job after TIMEOUT consecutive idle operand cycles.
module mac_job_sequencer
    import mac_job_seq_pkg::*;
#(
    parameter int unsigned NUM_REQ        = DefNumReq,
    parameter int unsigned bitwidthA      = 8,
    parameter int unsigned bitwidthB      = 8,
    parameter int unsigned AccCycles      = DefAccCycles,
    parameter int unsigned bitwidthAccRes = 25,
    parameter int unsigned DRAIN_CYCLES   = 2
`ifdef MAC_JOB_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT        = 1024
`endif
) (
    input logic                clk,
    input logic                reset,
    mac_job_sequencer_if.slave bus
);

    localparam int unsigned idW    = clog2(NUM_REQ);
    localparam int unsigned cntW   = clog2(AccCycles + 1);
    localparam int unsigned drainW = clog2(DRAIN_CYCLES + 1);

    seqState_e                 stateQ, stateD;
    logic [idW-1:0]            gntIdQ, gntIdD;
    logic [idW-1:0]            rrPtrQ, rrPtrD;
    logic [cntW-1:0]           cntQ, cntD;
    logic [drainW-1:0]         drainQ, drainD;
    logic                      macNewDataQ, macNewDataD;
    logic [bitwidthA-1:0]      macOpAQ, macOpAD;
    logic [bitwidthB-1:0]      macOpBQ, macOpBD;
    logic [bitwidthAccRes-1:0] resDataQ, resDataD;
    logic [idW-1:0]            resIdQ, resIdD;

    logic [idW-1:0]       arbId;
    logic                 arbAny;
    logic [bitwidthA-1:0] selA;
    logic [bitwidthB-1:0] selB;
    logic                 selValid;
    logic                 accOpen;
    logic                 xfer;
    logic [NUM_REQ-1:0]   opReady;

`ifdef MAC_JOB_SEQ_TIMEOUT_EN
    localparam int unsigned idleW = clog2(TIMEOUT + 1);
    logic [idleW-1:0] idleQ, idleD;
    logic             resErrQ, resErrD;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .idW     (idW)
    ) uArb (
        .req    (bus.req),
        .rrPtr  (rrPtrQ),
        .gntId  (arbId),
        .gntAny (arbAny)
    );

    // Route the granted requester's operand slices and valid bit.
    always_comb begin
        selA     = '0;
        selB     = '0;
        selValid = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gntIdQ == idW'(i)) begin
                selA     = bus.opA_in[i*bitwidthA +: bitwidthA];
                selB     = bus.opB_in[i*bitwidthB +: bitwidthB];
                selValid = bus.op_valid[i];
            end
        end
    end

    assign accOpen = (stateQ == StAccum) && (cntQ < cntW'(AccCycles));
    assign xfer    = accOpen && selValid;

    // Only the granted requester sees ready, and only while pairs are still owed.
    always_comb begin
        opReady = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            opReady[i] = accOpen && (gntIdQ == idW'(i));
        end
    end

    // Next-state logic for the job FSM, its counters and the result registers.
    always_comb begin
        stateD      = stateQ;
        gntIdD      = gntIdQ;
        rrPtrD      = rrPtrQ;
        cntD        = cntQ;
        drainD      = drainQ;
        macNewDataD = 1'b0;
        macOpAD     = macOpAQ;
        macOpBD     = macOpBQ;
        resDataD    = resDataQ;
        resIdD      = resIdQ;
`ifdef MAC_JOB_SEQ_TIMEOUT_EN
        idleD       = idleQ;
        resErrD     = resErrQ;
`endif
        unique case (stateQ)
            StIdle: begin
                if (arbAny) begin
                    gntIdD = arbId;
                    stateD = StClear;
                end
            end
            StClear: begin
                cntD   = '0;
                drainD = '0;
                stateD = StAccum;
`ifdef MAC_JOB_SEQ_TIMEOUT_EN
                idleD   = '0;
                resErrD = 1'b0;
`endif
            end
            StAccum: begin
                if (xfer) begin
                    macOpAD     = selA;
                    macOpBD     = selB;
                    macNewDataD = 1'b1;
                    cntD        = cntQ + cntW'(1);
`ifdef MAC_JOB_SEQ_TIMEOUT_EN
                    idleD       = '0;
`endif
                end else if (!accOpen) begin
                    stateD = StDrain;
`ifdef MAC_JOB_SEQ_TIMEOUT_EN
                end else if (idleQ == idleW'(TIMEOUT - 1)) begin
                    resDataD = '0;
                    resIdD   = gntIdQ;
                    resErrD  = 1'b1;
                    stateD   = StOutput;
                end else begin
                    idleD = idleQ + idleW'(1);
`endif
                end
            end
            StDrain: begin
                // Capture on the last drain cycle, when the accumulator has settled.
                if (drainQ == drainW'(DRAIN_CYCLES - 1)) begin
                    resDataD = bus.mac_result;
                    resIdD   = gntIdQ;
                    stateD   = StOutput;
                end else begin
                    drainD = drainQ + drainW'(1);
                end
            end
            StOutput: begin
                if (bus.res_ready) begin
                    rrPtrD = (gntIdQ == idW'(NUM_REQ - 1)) ? '0 : gntIdQ + idW'(1);
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    // State and output registers; reset drops any job in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ      <= StIdle;
            gntIdQ      <= '0;
            rrPtrQ      <= '0;
            cntQ        <= '0;
            drainQ      <= '0;
            macNewDataQ <= 1'b0;
            macOpAQ     <= '0;
            macOpBQ     <= '0;
            resDataQ    <= '0;
            resIdQ      <= '0;
`ifdef MAC_JOB_SEQ_TIMEOUT_EN
            idleQ       <= '0;
            resErrQ     <= 1'b0;
`endif
        end else begin
            stateQ      <= stateD;
            gntIdQ      <= gntIdD;
            rrPtrQ      <= rrPtrD;
            cntQ        <= cntD;
            drainQ      <= drainD;
            macNewDataQ <= macNewDataD;
            macOpAQ     <= macOpAD;
            macOpBQ     <= macOpBD;
            resDataQ    <= resDataD;
            resIdQ      <= resIdD;
`ifdef MAC_JOB_SEQ_TIMEOUT_EN
            idleQ       <= idleD;
            resErrQ     <= resErrD;
`endif
        end
    end

    assign bus.op_ready    = opReady;
    assign bus.mac_reset   = (stateQ == StClear);
    assign bus.mac_newData = macNewDataQ;
    assign bus.mac_opA     = macOpAQ;
    assign bus.mac_opB     = macOpBQ;
    assign bus.res_valid   = (stateQ == StOutput);
    assign bus.res_id      = resIdQ;
    assign bus.res_data    = resDataQ;
    assign bus.busy        = (stateQ != StIdle);
`ifdef MAC_JOB_SEQ_TIMEOUT_EN
    assign bus.res_err     = resErrQ;
`else
    assign bus.res_err     = 1'b0;
`endif

endmodule
